// File: rtl/tx8b10b_pkg.sv
// Shared definitions for the 8b10b TX framing path.
// Holds the K-code byte values and the framer state encoding. The RX deframer
// and the K-code test generator import the same package.
package tx8b10b_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;  // comma / idle / filler
    localparam logic [7:0] K27_7 = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7 = 8'hFD;  // end of frame

    typedef enum logic [2:0] {
        IDLE,
        SOF,
        DATA,
        CKSUM,
        EOF,
        DISCARD
    } frame_state_t;

endpackage

// File: rtl/tx_frame_cksum.sv
// 8-bit modulo-256 byte accumulator used as the frame checksum.
// Ports:
//   clk_i   in  1  clock
//   rst_i   in  1  asynchronous active-high reset, clears the sum
//   clr_i   in  1  synchronous clear (takes priority over add)
//   add_i   in  1  add data_i into the sum on this edge
//   data_i  in  8  byte to accumulate
//   sum_o   out 8  current accumulated value
module tx_frame_cksum (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clr_i,
    input  logic       add_i,
    input  logic [7:0] data_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q;
    logic [7:0] sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (add_i) begin
            sum_d = sum_q + data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/tx_frame_gen.sv
// TX framing stage feeding the 8b10b encoder directly.
// Converts a valid/ready byte stream into per-cycle KI/DATAIN symbols:
//   K27.7 SOF, payload D-chars, checksum D-char, K29.7 EOF,
// with K28.5 commas on idle, underrun and every COMMA_PERIOD payload bytes.
// Ports:
//   CLK_100_TX    in   1   TX byte clock (shared with the encoder)
//   RESET         in   1   asynchronous active-high reset
//   S_DATA        in   8   payload byte
//   S_VALID       in   1   S_DATA/S_LAST valid
//   S_LAST        in   1   final payload byte of the frame
//   S_READY       out  1   byte accepted on S_VALID && S_READY
//   KI            out  1   encoder KI (1 = control character)
//   DATAIN        out  8   encoder DATAIN
//   FRAME_ACTIVE  out  1   high from the SOF symbol through the EOF symbol
//   LEN_ERR       out  1   one-cycle pulse on the checksum of a truncated frame
//   FRAME_CNT     out  16  number of EOFs sent, wrapping
//
// state   | meaning
// IDLE    | emit K28.5, count idle cycles, wait for S_VALID after IDLE_MIN
// SOF     | emit K27.7, clear checksum/length/run counters
// DATA    | pass payload bytes; K28.5 on underrun or forced comma
// CKSUM   | emit the checksum byte
// EOF     | emit K29.7, bump FRAME_CNT, restart idle counting
// DISCARD | emit K28.5, swallow the rest of a truncated upstream frame
module tx_frame_gen
    import tx8b10b_pkg::*;
#(
    parameter int IDLE_MIN     = 4,
    parameter int COMMA_PERIOD = 64,
    parameter int MAX_LEN      = 256
) (
    input  logic        CLK_100_TX,
    input  logic        RESET,
    input  logic [7:0]  S_DATA,
    input  logic        S_VALID,
    input  logic        S_LAST,
    output logic        S_READY,
    output logic        KI,
    output logic [7:0]  DATAIN,
    output logic        FRAME_ACTIVE,
    output logic        LEN_ERR,
    output logic [15:0] FRAME_CNT
);

    localparam int IW = $clog2(IDLE_MIN + 1);
    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int RW = $clog2(COMMA_PERIOD + 1);

    localparam logic [IW-1:0] IDLE_MIN_C = IW'(IDLE_MIN);
    localparam logic [LW-1:0] LEN_LAST_C = LW'(MAX_LEN - 1);
    localparam logic [RW-1:0] COMMA_C    = RW'(COMMA_PERIOD);

    frame_state_t  state_q, state_d;
    logic [IW-1:0] idle_cnt_q, idle_cnt_d;
    logic [LW-1:0] len_q, len_d;
    logic [RW-1:0] run_q, run_d;
    logic          trunc_q, trunc_d;
    logic          ki_q, ki_d;
    logic [7:0]    data_q, data_d;
    logic          active_q, active_d;
    logic          len_err_q, len_err_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    logic          comma_due;
    logic          cks_clr;
    logic          cks_add;
    logic [7:0]    cks_sum;

    assign comma_due = (run_q == COMMA_C);

    tx_frame_cksum u_cksum (
        .clk_i  (CLK_100_TX),
        .rst_i  (RESET),
        .clr_i  (cks_clr),
        .add_i  (cks_add),
        .data_i (S_DATA),
        .sum_o  (cks_sum)
    );

    always_comb begin
        state_d     = state_q;
        idle_cnt_d  = idle_cnt_q;
        len_d       = len_q;
        run_d       = run_q;
        trunc_d     = trunc_q;
        ki_d        = 1'b1;
        data_d      = K28_5;
        active_d    = 1'b0;
        len_err_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        S_READY     = 1'b0;
        cks_clr     = 1'b0;
        cks_add     = 1'b0;

        case (state_q)
            IDLE: begin
                if (idle_cnt_q != IDLE_MIN_C) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
                if ((idle_cnt_q == IDLE_MIN_C) && S_VALID) begin
                    state_d = SOF;
                end
            end
            SOF: begin
                data_d   = K27_7;
                active_d = 1'b1;
                cks_clr  = 1'b1;
                len_d    = '0;
                run_d    = '0;
                trunc_d  = 1'b0;
                state_d  = DATA;
            end
            DATA: begin
                active_d = 1'b1;
                // Ready is withheld on a forced comma, so a pending S_LAST waits behind it.
                S_READY  = !comma_due;
                if (S_VALID && !comma_due) begin
                    ki_d    = 1'b0;
                    data_d  = S_DATA;
                    cks_add = 1'b1;
                    len_d   = len_q + LW'(1);
                    run_d   = run_q + RW'(1);
                    if (S_LAST) begin
                        state_d = CKSUM;
                    end else if (len_q == LEN_LAST_C) begin
                        state_d = CKSUM;
                        trunc_d = 1'b1;
                    end
                end else begin
                    // Any K28.5 inside the frame restarts the comma spacing.
                    run_d = '0;
                end
            end
            CKSUM: begin
                ki_d      = 1'b0;
                data_d    = cks_sum;
                active_d  = 1'b1;
                len_err_d = trunc_q;
                state_d   = EOF;
            end
            EOF: begin
                data_d      = K29_7;
                active_d    = 1'b1;
                frame_cnt_d = frame_cnt_q + 16'd1;
                idle_cnt_d  = '0;
                state_d     = trunc_q ? DISCARD : IDLE;
            end
            DISCARD: begin
                S_READY = 1'b1;
                if (idle_cnt_q != IDLE_MIN_C) begin
                    idle_cnt_d = idle_cnt_q + IW'(1);
                end
                if (S_VALID && S_LAST) begin
                    trunc_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_100_TX or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            idle_cnt_q  <= '0;
            len_q       <= '0;
            run_q       <= '0;
            trunc_q     <= 1'b0;
            ki_q        <= 1'b1;
            data_q      <= K28_5;
            active_q    <= 1'b0;
            len_err_q   <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            idle_cnt_q  <= idle_cnt_d;
            len_q       <= len_d;
            run_q       <= run_d;
            trunc_q     <= trunc_d;
            ki_q        <= ki_d;
            data_q      <= data_d;
            active_q    <= active_d;
            len_err_q   <= len_err_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign KI           = ki_q;
    assign DATAIN       = data_q;
    assign FRAME_ACTIVE = active_q;
    assign LEN_ERR      = len_err_q;
    assign FRAME_CNT    = frame_cnt_q;

endmodule

// File: tb/tb_tx_frame_gen.sv
// Bench for tx_frame_gen: two instances (comma period 4 / length 256, and
// comma period 64 / length 8) driven by directed and random frames, checked
// every cycle against a symbol-stream model plus literal frame images.
module tb_tx_frame_gen;

    localparam int P_IDLE = 4;
    localparam int BC = 8'hBC;
    localparam int FB = 8'hFB;
    localparam int FD = 8'hFD;

    logic       clk = 1'b0;
    logic       RESET;
    logic [7:0] s_data  [2];
    logic       s_valid [2];
    logic       s_last  [2];
    logic       s_ready [2];
    logic       ki      [2];
    logic [7:0] din     [2];
    logic       fa      [2];
    logic       lerr    [2];
    logic [15:0] fcnt   [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    tx_frame_gen #(.IDLE_MIN(4), .COMMA_PERIOD(4), .MAX_LEN(256)) dut_a (
        .CLK_100_TX(clk), .RESET(RESET),
        .S_DATA(s_data[0]), .S_VALID(s_valid[0]), .S_LAST(s_last[0]), .S_READY(s_ready[0]),
        .KI(ki[0]), .DATAIN(din[0]), .FRAME_ACTIVE(fa[0]), .LEN_ERR(lerr[0]), .FRAME_CNT(fcnt[0])
    );

    tx_frame_gen #(.IDLE_MIN(4), .COMMA_PERIOD(64), .MAX_LEN(8)) dut_b (
        .CLK_100_TX(clk), .RESET(RESET),
        .S_DATA(s_data[1]), .S_VALID(s_valid[1]), .S_LAST(s_last[1]), .S_READY(s_ready[1]),
        .KI(ki[1]), .DATAIN(din[1]), .FRAME_ACTIVE(fa[1]), .LEN_ERR(lerr[1]), .FRAME_CNT(fcnt[1])
    );

    function automatic int p_cp(int i);
        return (i == 0) ? 4 : 64;
    endfunction

    function automatic int p_max(int i);
        return (i == 0) ? 256 : 8;
    endfunction

    function automatic int sym(int le, int k, int d);
        return (le << 9) | (k << 8) | (d & 255);
    endfunction

    task automatic chk(string nm, int inst, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    // Model: what the symbol stream must look like, tracked as frame/trailer/idle bookkeeping.
    bit m_sof [2], m_in [2], m_disc [2], m_trunc [2];
    int m_len [2], m_run [2], m_sum [2], m_gap [2], m_tl [2], m_fcnt [2];
    bit m_ki [2], m_act [2], m_lerr [2];
    int m_dat [2];

    function automatic bit m_ready(int i);
        if (m_sof[i] || m_tl[i] != 0) return 1'b0;
        if (m_in[i]) return (m_run[i] != p_cp(i));
        return m_disc[i];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_sof[i] = 0; m_in[i] = 0; m_disc[i] = 0; m_trunc[i] = 0;
            m_len[i] = 0; m_run[i] = 0; m_sum[i] = 0; m_gap[i] = 0; m_tl[i] = 0; m_fcnt[i] = 0;
            m_ki[i] = 1; m_dat[i] = BC; m_act[i] = 0; m_lerr[i] = 0;
        end
    endtask

    task automatic m_step(int i);
        bit rdy, v, l;
        int d;
        rdy = m_ready(i);
        v = s_valid[i];
        l = s_last[i];
        d = int'(s_data[i]);
        m_ki[i] = 1; m_dat[i] = BC; m_act[i] = 0; m_lerr[i] = 0;
        if (m_sof[i]) begin
            m_dat[i] = FB; m_act[i] = 1; m_sof[i] = 0; m_in[i] = 1;
            m_len[i] = 0; m_run[i] = 0; m_sum[i] = 0;
        end else if (m_tl[i] == 2) begin
            m_ki[i] = 0; m_dat[i] = m_sum[i]; m_act[i] = 1; m_lerr[i] = m_trunc[i]; m_tl[i] = 1;
        end else if (m_tl[i] == 1) begin
            m_dat[i] = FD; m_act[i] = 1; m_tl[i] = 0; m_in[i] = 0;
            m_fcnt[i] = (m_fcnt[i] + 1) % 65536; m_gap[i] = 0;
            m_disc[i] = m_trunc[i]; m_trunc[i] = 0;
        end else if (m_in[i]) begin
            m_act[i] = 1;
            if (v && rdy) begin
                m_ki[i] = 0; m_dat[i] = d; m_sum[i] = (m_sum[i] + d) % 256;
                m_len[i]++; m_run[i]++;
                if (l || m_len[i] == p_max(i)) begin
                    m_tl[i] = 2;
                    m_trunc[i] = !l;
                end
            end else begin
                m_run[i] = 0;
            end
        end else begin
            if (m_disc[i]) begin
                if (v && l) m_disc[i] = 0;
            end else if (m_gap[i] >= P_IDLE && v) begin
                m_sof[i] = 1;
            end
            if (m_gap[i] < P_IDLE) m_gap[i]++;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge RESET);
            if (RESET) m_reset();
            else begin
                m_step(0);
                m_step(1);
            end
        end
    end

    // Per-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (!RESET) begin
                for (int i = 0; i < 2; i++) begin
                    chk("S_READY", i, s_ready[i], m_ready(i));
                    chk("KI", i, ki[i], m_ki[i]);
                    chk("DATAIN", i, din[i], m_dat[i]);
                    chk("FRAME_ACTIVE", i, fa[i], m_act[i]);
                    chk("LEN_ERR", i, lerr[i], m_lerr[i]);
                    chk("FRAME_CNT", i, fcnt[i], m_fcnt[i]);
                end
            end
        end
    end

    // Capture of in-frame symbols for the literal frame images.
    int cap [2][$];
    int eof_cnt [2];
    int gap_run [2];
    int last_gap [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            eof_cnt[i] = 0; gap_run[i] = 0; last_gap[i] = -1;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (RESET) begin
                    gap_run[i] = 0;
                end else if (fa[i]) begin
                    cap[i].push_back(sym(int'(lerr[i]), int'(ki[i]), int'(din[i])));
                    if (ki[i] && din[i] == 8'hFB) last_gap[i] = gap_run[i];
                    if (ki[i] && din[i] == 8'hFD) eof_cnt[i]++;
                    gap_run[i] = 0;
                end else begin
                    gap_run[i]++;
                end
            end
        end
    end

    task automatic send_frame(input int i, input int n, input int first, input bit rnd,
                              input int stall_pct, input int drop_at, input int drop_len);
        int k, dropped, cyc;
        bit v, rdy;
        logic [7:0] cur;
        k = 0; dropped = 0; cyc = 0;
        cur = rnd ? 8'($urandom_range(0, 255)) : 8'(first);
        while (k < n) begin
            if (k == drop_at && dropped < drop_len) begin
                v = 0;
                dropped++;
            end else begin
                v = ($urandom_range(0, 99) >= stall_pct);
            end
            s_valid[i] = v;
            s_data[i]  = cur;
            s_last[i]  = (k == n - 1);
            @(negedge clk);
            rdy = s_ready[i];
            @(posedge clk);
            #1;
            if (v && rdy) begin
                k++;
                cur = rnd ? 8'($urandom_range(0, 255)) : 8'(first + k);
            end
            cyc++;
            if (cyc > 2000) begin
                chk("send_timeout", i, k, n);
                break;
            end
        end
        s_valid[i] = 0;
        s_last[i]  = 0;
    endtask

    task automatic wait_eof(input int i, input int target);
        for (int c = 0; c < 200 && eof_cnt[i] < target; c++) begin
            @(negedge clk);
            #1;
        end
        if (eof_cnt[i] < target) chk("eof_timeout", i, eof_cnt[i], target);
    endtask

    task automatic check_frames(input int i, input string nm, input int e[$]);
        chk({nm, "_len"}, i, cap[i].size(), e.size());
        for (int k = 0; k < e.size() && k < cap[i].size(); k++) begin
            chk(nm, i, cap[i][k], e[k]);
        end
    endtask

    task automatic start_capture(input int i);
        cap[i].delete();
        eof_cnt[i] = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e[$];
        int bc_cnt, rdy_hi, npay;
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_data[i] = 8'h00; s_valid[i] = 1'b0; s_last[i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("rst_KI", 0, ki[0], 1);
        chk("rst_DATAIN", 0, din[0], 8'hBC);
        chk("rst_FRAME_CNT", 0, fcnt[0], 0);
        RESET = 1'b0;

        // Idle with no traffic.
        bc_cnt = 0; rdy_hi = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (ki[0] && din[0] == 8'hBC) bc_cnt++;
            if (s_ready[0]) rdy_hi++;
        end
        chk("idle_bc_cycles", 0, bc_cnt, 20);
        chk("idle_ready_cycles", 0, rdy_hi, 0);
        chk("idle_frame_cnt", 0, fcnt[0], 0);
        @(posedge clk);
        #1;

        // 3-byte frame then a 10-byte frame back to back on inst 0 (comma every 4).
        start_capture(0);
        send_frame(0, 3, 8'h01, 0, 0, -1, 0);
        send_frame(0, 10, 8'h00, 0, 0, -1, 0);
        wait_eof(0, 2);
        e = '{sym(0,1,'hFB), sym(0,0,'h01), sym(0,0,'h02), sym(0,0,'h03), sym(0,0,'h06), sym(0,1,'hFD),
              sym(0,1,'hFB), sym(0,0,'h00), sym(0,0,'h01), sym(0,0,'h02), sym(0,0,'h03), sym(0,1,'hBC),
              sym(0,0,'h04), sym(0,0,'h05), sym(0,0,'h06), sym(0,0,'h07), sym(0,1,'hBC),
              sym(0,0,'h08), sym(0,0,'h09), sym(0,0,'h2D), sym(0,1,'hFD)};
        check_frames(0, "frame3_then_comma10", e);
        chk("idle_gap_ge4", 0, (last_gap[0] >= 4), 1);
        chk("frame_cnt_after2", 0, fcnt[0], 2);

        // Underrun: S_VALID low for 3 cycles after the 2nd byte.
        start_capture(0);
        send_frame(0, 5, 8'h10, 0, 0, 2, 3);
        wait_eof(0, 1);
        e = '{sym(0,1,'hFB), sym(0,0,'h10), sym(0,0,'h11), sym(0,1,'hBC), sym(0,1,'hBC), sym(0,1,'hBC),
              sym(0,0,'h12), sym(0,0,'h13), sym(0,0,'h14), sym(0,0,'h5A), sym(0,1,'hFD)};
        check_frames(0, "underrun_fill", e);

        // Truncation at MAX_LEN=8 on inst 1, then an exactly-8-byte frame.
        start_capture(1);
        send_frame(1, 12, 8'h20, 0, 0, -1, 0);
        send_frame(1, 8, 8'h30, 0, 0, -1, 0);
        wait_eof(1, 2);
        e = '{sym(0,1,'hFB), sym(0,0,'h20), sym(0,0,'h21), sym(0,0,'h22), sym(0,0,'h23),
              sym(0,0,'h24), sym(0,0,'h25), sym(0,0,'h26), sym(0,0,'h27), sym(1,0,'h1C), sym(0,1,'hFD),
              sym(0,1,'hFB), sym(0,0,'h30), sym(0,0,'h31), sym(0,0,'h32), sym(0,0,'h33),
              sym(0,0,'h34), sym(0,0,'h35), sym(0,0,'h36), sym(0,0,'h37), sym(0,0,'h9C), sym(0,1,'hFD)};
        check_frames(1, "trunc_then_max", e);
        chk("trunc_frame_cnt", 1, fcnt[1], 2);

        // Random traffic on both instances, checked by the model every cycle.
        fork
            begin
                for (int f = 0; f < 15; f++) begin
                    send_frame(0, $urandom_range(1, 20), 0, 1, 25, -1, 0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
            begin
                for (int f = 0; f < 15; f++) begin
                    send_frame(1, $urandom_range(1, 14), 0, 1, 25, -1, 0);
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    #1;
                end
            end
        join
        repeat (30) @(posedge clk);
        #1;

        // Reset while the 2nd payload byte is on the output.
        s_valid[0] = 1'b1; s_data[0] = 8'h40; s_last[0] = 1'b0;
        npay = 0;
        for (int c = 0; c < 100 && npay < 2; c++) begin
            @(negedge clk);
            if (fa[0] && !ki[0]) npay++;
        end
        chk("reset_reach_2nd_byte", 0, npay, 2);
        #2;
        RESET = 1'b1;
        #1;
        chk("async_rst_KI", 0, ki[0], 1);
        chk("async_rst_DATAIN", 0, din[0], 8'hBC);
        chk("async_rst_FRAME_ACTIVE", 0, fa[0], 0);
        chk("async_rst_FRAME_CNT", 0, fcnt[0], 0);
        chk("async_rst_S_READY", 0, s_ready[0], 0);
        s_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start_capture(0);
        RESET = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("no_eof_after_reset", 0, eof_cnt[0], 0);
        chk("frame_cnt_after_reset", 0, fcnt[0], 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
